// File: rtl/fft_pkg.sv
// Shared types and defaults for the 4-point FFT engine and its frame sequencer.
package fft_pkg;

    localparam int unsigned FFT_WIDTH  = 16;
    localparam int unsigned FFT_POINTS = 4;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT,
        DRAIN,
        GAP
    } fft_ctrl_state_t;

    typedef logic [FFT_POINTS-1:0][FFT_WIDTH-1:0] sample_frame_t;

endpackage

// File: rtl/fft_bin_buffer.sv
// Four-entry bin register file: captures all engine bins in parallel, reads one by index.
module fft_bin_buffer
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_capture,
    input  logic [FFT_POINTS-1:0][WIDTH-1:0] i_bins,
    input  logic [1:0]                       i_rd_idx,
    output logic [WIDTH-1:0]                 o_rd_data
);

    logic [FFT_POINTS-1:0][WIDTH-1:0] r_bins;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bins <= '0;
        end else if (i_capture) begin
            r_bins <= i_bins;
        end
    end

    assign o_rd_data = r_bins[i_rd_idx];

endmodule

// File: rtl/fft_frame_controller.sv
// Frame sequencer for the 4-point FFT engine: load four samples, start the engine,
// wait for a trusted done or time out, drain the bins, then hold a start-low gap.
module fft_frame_controller
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH   = FFT_WIDTH,
    parameter int unsigned MIN_LAT = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned GAP     = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [WIDTH-1:0]                 sample_in,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    output logic [FFT_POINTS-1:0][WIDTH-1:0] eng_samples,
    output logic                             eng_start,
    input  logic                             eng_done,
    input  logic [FFT_POINTS-1:0][WIDTH-1:0] eng_freqs,
    output logic [WIDTH-1:0]                 freq_out,
    output logic [1:0]                       freq_idx,
    output logic                             freq_valid,
    input  logic                             freq_ready,
    output logic [7:0]                       frame_cnt,
    output logic                             timeout_err
);

    localparam int unsigned WCW = $clog2(TIMEOUT + 1);
    localparam int unsigned GCW = $clog2(GAP + 2);

    fft_ctrl_state_t                  r_state;
    fft_ctrl_state_t                  w_next_state;
    logic [1:0]                       r_ld_idx;
    logic [WCW-1:0]                   r_wait_cnt;
    logic [GCW-1:0]                   r_gap_cnt;
    logic [1:0]                       r_out_idx;
    logic [7:0]                       r_frame_cnt;
    logic                             r_timeout_err;
    logic                             r_sample_ready;
    logic                             r_eng_start;
    logic [FFT_POINTS-1:0][WIDTH-1:0] r_eng_samples;

    logic                             w_accept;
    logic                             w_qual_done;
    logic                             w_timeout;
    logic                             w_bin_accept;
    logic                             w_last_bin;
    logic                             w_gap_met;
    logic                             w_draining;
    logic [WIDTH-1:0]                 w_rd_data;

    // Done is only trusted once the engine has had MIN_LAT cycles; a stale level is ignored.
    assign w_accept     = sample_valid && r_sample_ready;
    assign w_qual_done  = (r_state == fft_pkg::WAIT) && eng_done
                          && (r_wait_cnt >= WCW'(MIN_LAT - 1));
    assign w_timeout    = (r_state == fft_pkg::WAIT) && !w_qual_done
                          && (r_wait_cnt == WCW'(TIMEOUT - 1));
    assign w_draining   = (r_state == fft_pkg::DRAIN);
    assign w_bin_accept = w_draining && freq_ready;
    assign w_last_bin   = w_bin_accept && (r_out_idx == 2'd3);
    assign w_gap_met    = (r_gap_cnt >= GCW'(GAP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= fft_pkg::LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            fft_pkg::LOAD:  if (w_accept && (r_ld_idx == 2'd3)) w_next_state = fft_pkg::START;
            fft_pkg::START: w_next_state = fft_pkg::WAIT;
            fft_pkg::WAIT: begin
                if (w_qual_done) begin
                    w_next_state = fft_pkg::DRAIN;
                end else if (w_timeout) begin
                    w_next_state = fft_pkg::GAP;
                end
            end
            fft_pkg::DRAIN: if (w_last_bin) w_next_state = fft_pkg::GAP;
            fft_pkg::GAP:   if (w_gap_met) w_next_state = fft_pkg::LOAD;
            default:        w_next_state = fft_pkg::LOAD;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample_ready <= 1'b0;
            r_eng_start    <= 1'b0;
        end else begin
            r_sample_ready <= (w_next_state == fft_pkg::LOAD);
            r_eng_start    <= (w_next_state == fft_pkg::START) || (w_next_state == fft_pkg::WAIT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eng_samples <= '0;
            r_ld_idx      <= '0;
        end else if (w_accept) begin
            r_eng_samples[r_ld_idx] <= sample_in;
            r_ld_idx                <= r_ld_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == fft_pkg::START) begin
            r_wait_cnt <= '0;
        end else if (r_state == fft_pkg::WAIT) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
    end

    // Gap counting starts at the start fall and saturates, so a long drain already covers it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= '0;
        end else if (w_qual_done || w_timeout) begin
            r_gap_cnt <= '0;
        end else if ((w_draining || (r_state == fft_pkg::GAP)) && !w_gap_met) begin
            r_gap_cnt <= r_gap_cnt + GCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_idx     <= '0;
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_bin_accept) begin
                r_out_idx <= r_out_idx + 2'd1;
            end
            if (w_last_bin) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    fft_bin_buffer #(
        .WIDTH(WIDTH)
    ) u_bin_buffer (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_capture (w_qual_done),
        .i_bins    (eng_freqs),
        .i_rd_idx  (r_out_idx),
        .o_rd_data (w_rd_data)
    );

    assign sample_ready = r_sample_ready;
    assign eng_samples  = r_eng_samples;
    assign eng_start    = r_eng_start;
    assign freq_valid   = w_draining;
    assign freq_out     = w_draining ? w_rd_data : '0;
    assign freq_idx     = r_out_idx;
    assign frame_cnt    = r_frame_cnt;
    assign timeout_err  = r_timeout_err;

endmodule
